convolution_procesor_sequencer: RTL

Control and datapath engine of the convolution processor. It computes Z[i] = sum over j of X[i-j]*Y[j] for i = 0..sizeX+sizeY-2. It walks the (i, j) index space, drives read addresses to the X and Y memories, and accumulates the products. Each finished Z[i] is written to the Z memory. Its outer and inner loop bounds are evaluated with the codebase's less-than comparator stage.

---
 rtl/convolution_procesor_pkg.sv | 20 ++
 rtl/convolution_procesor_comparatorLessThan.sv | 12 +
 rtl/convolution_procesor_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/convolution_procesor_pkg.sv
// Shared definitions for the convolution processor: default widths and the
// sequencer FSM state encoding.
package convolution_procesor_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_ADDR_WIDTH_X = 5;
    localparam int DEF_ADDR_WIDTH_Y = 5;
    localparam int DEF_ADDR_WIDTH_Z = 6;
    // Worst-case sum of 2^ADDR_WIDTH_Y full-scale products fits exactly.
    localparam int DEF_ACC_WIDTH    = 2 * DEF_DATA_WIDTH + DEF_ADDR_WIDTH_Y;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/convolution_procesor_comparatorLessThan.sv
// Unsigned less-than comparator used for the sequencer loop bounds.
module convolution_procesor_comparatorLessThan #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             lt_o
);

    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/convolution_procesor_sequencer.sv
// Convolution sequencer: walks the (i, j) index space, issues X/Y reads,
// accumulates the returning products and writes each finished Z[i].
module convolution_procesor_sequencer
    import convolution_procesor_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH_X = DEF_ADDR_WIDTH_X,
    parameter int ADDR_WIDTH_Y = DEF_ADDR_WIDTH_Y,
    parameter int ADDR_WIDTH_Z = DEF_ADDR_WIDTH_Z,
    parameter int ACC_WIDTH    = 2 * DATA_WIDTH + ADDR_WIDTH_Y
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH_X:0]   sizeX_i,
    input  logic [ADDR_WIDTH_Y:0]   sizeY_i,
    output logic [ADDR_WIDTH_X-1:0] memX_addr_o,
    input  logic [DATA_WIDTH-1:0]   memX_data_i,
    output logic [ADDR_WIDTH_Y-1:0] memY_addr_o,
    input  logic [DATA_WIDTH-1:0]   memY_data_i,
    output logic [ADDR_WIDTH_Z-1:0] memZ_addr_o,
    output logic [ACC_WIDTH-1:0]    memZ_data_o,
    output logic                    memZ_we_o,
    output logic                    busy_o,
    output logic                    done_o
);

    // Common comparison width: wide enough for i, sizeX+sizeY and the sizes.
    localparam int CW = ADDR_WIDTH_Z + 1;

    state_t state, state_nxt;

    logic [ADDR_WIDTH_X:0]   size_x;
    logic [ADDR_WIDTH_Y:0]   size_y;
    logic [ADDR_WIDTH_Z-1:0] i_idx;
    logic [ADDR_WIDTH_Y-1:0] j_idx;
    logic [ACC_WIDTH-1:0]    acc;
    logic                    vld_p0;
    logic                    vld_p1;

    logic [CW-1:0] i_ext;
    logic [CW-1:0] j_ext;
    logic [CW-1:0] diff;
    logic [CW-1:0] sx_ext;
    logic [CW-1:0] sy_last;
    logic [CW-1:0] i_last;
    logic          x_in_range;
    logic          j_more;
    logic          i_more;
    logic          j_le_i;
    logic [ACC_WIDTH-1:0] prod;

    assign i_ext   = CW'(i_idx);
    assign j_ext   = CW'(j_idx);
    assign diff    = i_ext - j_ext;
    assign sx_ext  = CW'(size_x);
    assign sy_last = CW'(size_y) - CW'(1);
    assign i_last  = CW'(size_x) + CW'(size_y) - CW'(2);

    // j <= i expressed as not (i < j); when false, diff has wrapped and is masked.
    assign j_le_i = !(i_ext < j_ext);
    assign vld_p0 = j_le_i && x_in_range;
    assign prod   = ACC_WIDTH'(memX_data_i) * ACC_WIDTH'(memY_data_i);

    convolution_procesor_comparatorLessThan #(.WIDTH(CW)) u_cmp_x_range (
        .a_i  (diff),
        .b_i  (sx_ext),
        .lt_o (x_in_range)
    );

    convolution_procesor_comparatorLessThan #(.WIDTH(CW)) u_cmp_inner (
        .a_i  (j_ext),
        .b_i  (sy_last),
        .lt_o (j_more)
    );

    convolution_procesor_comparatorLessThan #(.WIDTH(CW)) u_cmp_outer (
        .a_i  (i_ext),
        .b_i  (i_last),
        .lt_o (i_more)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Loop indices, latched sizes, valid pipe and accumulator.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            size_x <= '0;
            size_y <= '0;
            i_idx  <= '0;
            j_idx  <= '0;
            acc    <= '0;
            vld_p1 <= 1'b0;
        end else begin
            // Stage p1: valid aligned with the data returning from X/Y memories.
            vld_p1 <= (state == ST_RUN) && vld_p0;
            if (vld_p1) begin
                acc <= acc + prod;
            end
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        size_x <= sizeX_i;
                        size_y <= sizeY_i;
                        i_idx  <= '0;
                        j_idx  <= '0;
                        acc    <= '0;
                    end
                end
                ST_RUN: begin
                    j_idx <= j_more ? (j_idx + ADDR_WIDTH_Y'(1)) : '0;
                end
                ST_WRITE: begin
                    acc <= '0;
                    if (i_more) begin
                        i_idx <= i_idx + ADDR_WIDTH_Z'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt   = state;
        memX_addr_o = '0;
        memY_addr_o = '0;
        memZ_addr_o = '0;
        memZ_data_o = '0;
        memZ_we_o   = 1'b0;
        busy_o      = (state != ST_IDLE);
        done_o      = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ((sizeX_i == '0) || (sizeY_i == '0)) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                memX_addr_o = diff[ADDR_WIDTH_X-1:0];
                memY_addr_o = j_idx;
                if (!j_more) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                memZ_we_o   = 1'b1;
                memZ_addr_o = i_idx;
                memZ_data_o = acc;
                state_nxt   = i_more ? ST_RUN : ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
